// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Latches the winning byte, strobes the transmitter, waits for done or timeout, then idles a gap.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned PULSE_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_start,
    input  logic                         tx_done,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [$clog2(NUM_REQ)-1:0]   err_id
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PuW  = $clog2(PULSE_CYCLES + 1);
    // A zero-length gap still needs a one-bit counter to keep the declaration legal.
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      last_q, last_d;
    logic [IdW-1:0]      cur_q, cur_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic [IdW-1:0]      err_id_q, err_id_d;
    logic                tx_done_q;
    logic [PuW-1:0]      pulse_cnt_q, pulse_cnt_d;
    logic [ToW-1:0]      to_cnt_q, to_cnt_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;

    logic                any_req;
    logic [IdW-1:0]      winner;
    int unsigned         arb_idx;
    logic                done_edge;
    logic                timed_out;

    assign done_edge = tx_done & ~tx_done_q;
    assign timed_out = (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

    // Descending scan so the smallest offset after last_q is written last and wins.
    always_comb begin
        any_req = 1'b0;
        winner  = last_q;
        arb_idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            arb_idx = (int'(last_q) + k) % NUM_REQ;
            if (req[arb_idx]) begin
                any_req = 1'b1;
                winner  = IdW'(arb_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            last_q        <= IdW'(NUM_REQ - 1);
            cur_q         <= '0;
            grant_q       <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            err_id_q      <= '0;
            tx_done_q     <= 1'b0;
            pulse_cnt_q   <= '0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cur_q         <= cur_d;
            grant_q       <= grant_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            err_id_q      <= err_id_d;
            tx_done_q     <= tx_done;
            pulse_cnt_q   <= pulse_cnt_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d     = StStart;
                    pulse_cnt_d = '0;
                end
            end
            StStart: begin
                if (pulse_cnt_q == PuW'(PULSE_CYCLES - 1)) begin
                    state_d  = StWait;
                    to_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PuW'(1);
                end
            end
            StWait: begin
                if (done_edge || timed_out) begin
                    state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
                    gap_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are computed from the transition so they line up with the new state.
    always_comb begin
        grant_d       = '0;
        tx_data_d     = tx_data_q;
        cur_d         = cur_q;
        last_d        = last_q;
        timeout_err_d = 1'b0;
        err_id_d      = err_id_q;
        if (state_q == StIdle && any_req) begin
            grant_d[winner] = 1'b1;
            tx_data_d       = req_data[winner*DATA_W +: DATA_W];
            cur_d           = winner;
            last_d          = winner;
        end
        // A done edge in the same cycle as the timeout takes precedence.
        if (state_q == StWait && !done_edge && timed_out) begin
            timeout_err_d = 1'b1;
            err_id_d      = cur_q;
        end
        tx_start_d = (state_d == StStart);
        busy_d     = (state_d != StIdle);
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign err_id      = err_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, contention, fairness, timeout,
// mid-WAIT reset and a behavioural serial link.
module tb_uart_tx_arbiter;

    localparam int unsigned PulseCycles   = 3;
    localparam int unsigned TimeoutCycles = 100;
    localparam int unsigned GapCycles     = 2;
    localparam int unsigned BitClks       = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic        timeout_err;
    logic [1:0]  err_id;

    logic        man_done;
    logic        auto_done;
    logic        uart_done;
    logic        link_mode;
    logic        auto_en;
    logic        line;
    logic [9:0]  frame;
    logic [7:0]  rx_byte;
    logic [7:0]  rx_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_seen = 0;

    assign tx_done = link_mode ? uart_done : (man_done | auto_done);

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .DATA_W         (8),
        .PULSE_CYCLES   (PulseCycles),
        .TIMEOUT_CYCLES (TimeoutCycles),
        .GAP_CYCLES     (GapCycles)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_id      (err_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (timeout_err) err_seen <= err_seen + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input string tag, output int idx);
        idx = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (grant != 4'b0) break;
        end
        check({tag, "_grant_seen"}, 32'(grant != 4'b0), 1);
        for (int j = 0; j < 4; j++) if (grant[j]) idx = j;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    // Acknowledges each byte five cycles after the start strobe ends.
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge tx_start);
            if (auto_en) begin
                repeat (5) @(negedge clk);
                auto_done = 1'b1;
                @(negedge clk);
                auto_done = 1'b0;
            end
        end
    end

    // Behavioural 8N1 transmitter, BitClks clocks per bit.
    initial begin
        line      = 1'b1;
        uart_done = 1'b0;
        forever begin
            @(posedge tx_start);
            if (link_mode) begin
                @(negedge clk);
                frame = {1'b1, tx_data, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    line = frame[i];
                    repeat (BitClks - 1) @(posedge clk);
                end
                @(negedge clk);
                uart_done = 1'b1;
                @(negedge clk);
                uart_done = 1'b0;
            end
        end
    end

    // Behavioural receiver sampling mid-bit.
    initial begin
        rx_byte = '0;
        forever begin
            @(negedge clk);
            if (link_mode && !line) begin
                repeat (BitClks / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BitClks) @(negedge clk);
                    rx_byte[i] = line;
                end
                repeat (BitClks) @(negedge clk);
                rx_q.push_back(rx_byte);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int pulses;
        int prev;
        int n;
        int e0;

        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        man_done  = 1'b0;
        link_mode = 1'b0;
        auto_en   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_err_id", 32'(err_id), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        reset = 1'b0;

        // Single request
        req           = 4'b0001;
        req_data[7:0] = 8'h41;
        @(negedge clk);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_tx_data", 32'(tx_data), 32'h41);
        check("t1_tx_start", 32'(tx_start), 1);
        check("t1_busy", 32'(busy), 1);
        req    = '0;
        pulses = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_grant_pulse", 32'(grant), 0);
            pulses += int'(tx_start);
        end
        check("t1_start_cycles", pulses, PulseCycles);
        repeat (39) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("t1_busy_gap0", 32'(busy), 1);
        check("t1_tx_data_held", 32'(tx_data), 32'h41);
        @(negedge clk);
        check("t1_busy_gap1", 32'(busy), 1);
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 0);
        check("t1_no_timeout", err_seen, 0);

        // Contention, all four requesting
        do_reset();
        auto_en  = 1'b1;
        req      = 4'b1111;
        req_data = 32'hA3A2_A1A0;
        prev     = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant("t2", idx);
            check($sformatf("t2_grant%0d", k), idx, k % 4);
            check($sformatf("t2_data%0d", k), 32'(tx_data), 32'hA0 + (k % 4));
            if (k > 0) check($sformatf("t2_spacing%0d", k), 32'((cyc - prev) >= 7), 1);
            prev = cyc;
            if (k == 4) req = '0;
        end
        wait_idle("t2");

        // Fairness between 0 and 2
        do_reset();
        req      = 4'b0101;
        req_data = 32'h00C2_00C0;
        for (int k = 0; k < 4; k++) begin
            wait_grant("t3", idx);
            check($sformatf("t3_grant%0d", k), idx, (k % 2) * 2);
            if (k == 3) req = '0;
        end
        wait_idle("t3");

        // Timeout
        do_reset();
        auto_en  = 1'b0;
        req      = 4'b0100;
        req_data = 32'h0077_0000;
        wait_grant("t4", idx);
        req = '0;
        check("t4_grant", idx, 2);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                n = i;
                break;
            end
        end
        check("t4_timeout_latency", n, PulseCycles + TimeoutCycles);
        check("t4_err_id", 32'(err_id), 2);
        @(negedge clk);
        check("t4_err_pulse", 32'(timeout_err), 0);
        wait_idle("t4");
        check("t4_err_count", err_seen, 1);
        auto_en       = 1'b1;
        req           = 4'b0001;
        req_data[7:0] = 8'h11;
        wait_grant("t4b", idx);
        req = '0;
        check("t4_next_grant", idx, 0);
        check("t4_next_data", 32'(tx_data), 32'h11);
        check("t4_err_id_held", 32'(err_id), 2);
        wait_idle("t4b");

        // Reset while waiting for done
        do_reset();
        auto_en  = 1'b0;
        req      = 4'b0010;
        req_data = 32'h0000_2200;
        wait_grant("t5", idx);
        req = '0;
        check("t5_grant", idx, 1);
        repeat (10) @(negedge clk);
        check("t5_busy_wait", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_grant_rst", 32'(grant), 0);
        check("t5_tx_start_rst", 32'(tx_start), 0);
        check("t5_busy_rst", 32'(busy), 0);
        check("t5_tx_data_rst", 32'(tx_data), 0);
        check("t5_timeout_rst", 32'(timeout_err), 0);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_late_done", 32'(busy), 0);
        req      = 4'b1111;
        req_data = 32'hA3A2_A1A0;
        wait_grant("t5b", idx);
        req     = '0;
        auto_en = 1'b1;
        check("t5_first_after_rst", idx, 0);
        wait_idle("t5b");

        // Serial link
        do_reset();
        auto_en   = 1'b0;
        link_mode = 1'b1;
        e0        = err_seen;
        req       = 4'b0011;
        req_data  = 32'h0000_5A41;
        for (int k = 0; k < 2; k++) begin
            wait_grant("t6", idx);
            check($sformatf("t6_grant%0d", k), idx, k);
            req = req & ~grant;
        end
        wait_idle("t6");
        repeat (10) @(negedge clk);
        check("t6_rx_count", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            check("t6_rx0", 32'(rx_q[0]), 32'h41);
            check("t6_rx1", 32'(rx_q[1]), 32'h5A);
        end
        check("t6_no_timeout", err_seen, e0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
